// File: rtl/ghash_tag_block.sv
// GHASH accumulator for AES-GCM: bit-serial GF(2^128) multiply, length block, tag and tag compare.
// 129 cycles per block or length block; sources hold their valid until accepted while oReady=1; tag held until iInit.
module ghash_tag_block (
   input  logic         iClk,
   input  logic         iRstn,
   input  logic         iInit,
   input  logic [0:127] iH,
   input  logic         iH_valid,
   input  logic [0:127] iEk0,
   input  logic         iEk0_valid,
   input  logic [0:127] iAad,
   input  logic         iAad_valid,
   input  logic [0:127] iCt,
   input  logic         iCt_valid,
   input  logic         iFinal,
   input  logic [0:63]  iLenA,
   input  logic [0:63]  iLenC,
   input  logic [0:127] iTag_ref,
   output logic         oReady,
   output logic         oBusy,
   output logic [0:127] oTag,
   output logic         oTag_valid,
   output logic         oTag_match
);

   typedef enum logic [2:0] {
      S_NOKEY,
      S_READY,
      S_MULT,
      S_FIN,
      S_DONE
   } state_t;

   localparam logic [0:127] R_POLY = {8'hE1, 120'd0};

   state_t       state_q;
   logic [0:127] h_q;
   logic [0:127] ek0_q;
   logic [0:127] y_q;
   logic [0:127] x_q;
   logic [0:127] z_q;
   logic [0:127] v_q;
   logic [0:127] tag_ref_q;
   logic [6:0]   cnt_q;

   logic [0:127] z_step;
   logic [0:127] v_step;
   logic [0:127] tag_calc;
   logic [0:127] blk_sel;
   logic         blk_take;
   logic         h_load;

   // One multiplier step: bit cnt of X selects V into Z, V advances by one power of x mod P.
   always_comb begin
      z_step   = x_q[cnt_q] ? (z_q ^ v_q) : z_q;
      v_step   = v_q[127] ? ((v_q >> 1) ^ R_POLY) : (v_q >> 1);
      tag_calc = z_step ^ ek0_q;
      blk_take = iAad_valid | iCt_valid;
      blk_sel  = iAad_valid ? iAad : iCt;
      h_load   = iH_valid && (state_q == S_NOKEY || state_q == S_READY ||
                              state_q == S_DONE || iInit);
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state_q    <= S_NOKEY;
         h_q        <= '0;
         ek0_q      <= '0;
         y_q        <= '0;
         x_q        <= '0;
         z_q        <= '0;
         v_q        <= '0;
         tag_ref_q  <= '0;
         cnt_q      <= '0;
         oReady     <= 1'b0;
         oBusy      <= 1'b0;
         oTag       <= '0;
         oTag_valid <= 1'b0;
         oTag_match <= 1'b0;
      end else begin
         if (iEk0_valid) ek0_q <= iEk0;
         if (h_load)     h_q   <= iH;

         if (state_q == S_NOKEY) begin
            if (iH_valid) begin
               state_q <= S_READY;
               oReady  <= 1'b1;
            end
         end else if (iInit) begin
            // Abort wins over any same-cycle accept or in-flight multiply.
            y_q        <= '0;
            oTag       <= '0;
            oTag_valid <= 1'b0;
            oTag_match <= 1'b0;
            oReady     <= 1'b1;
            oBusy      <= 1'b0;
            state_q    <= S_READY;
         end else begin
            case (state_q)
               S_READY: begin
                  if (blk_take || iFinal) begin
                     x_q    <= y_q ^ (blk_take ? blk_sel : {iLenA, iLenC});
                     z_q    <= '0;
                     v_q    <= h_q;
                     cnt_q  <= '0;
                     oReady <= 1'b0;
                     oBusy  <= 1'b1;
                     if (blk_take) begin
                        state_q <= S_MULT;
                     end else begin
                        tag_ref_q <= iTag_ref;
                        state_q   <= S_FIN;
                     end
                  end
               end
               S_MULT, S_FIN: begin
                  z_q   <= z_step;
                  v_q   <= v_step;
                  cnt_q <= cnt_q + 7'd1;
                  if (cnt_q == 7'd127) begin
                     y_q   <= z_step;
                     oBusy <= 1'b0;
                     if (state_q == S_FIN) begin
                        oTag       <= tag_calc;
                        oTag_match <= (tag_calc == tag_ref_q);
                        oTag_valid <= 1'b1;
                        state_q    <= S_DONE;
                     end else begin
                        oReady  <= 1'b1;
                        state_q <= S_READY;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ghash_tag_block.sv
// Bench for ghash_tag_block: polynomial-arithmetic model checked every cycle plus 802.1AE GCM-AES-256 literals.
module tb_ghash_tag_block;

   logic         iClk = 1'b0;
   logic         iRstn;
   logic         iInit;
   logic [0:127] iH;
   logic         iH_valid;
   logic [0:127] iEk0;
   logic         iEk0_valid;
   logic [0:127] iAad;
   logic         iAad_valid;
   logic [0:127] iCt;
   logic         iCt_valid;
   logic         iFinal;
   logic [0:63]  iLenA;
   logic [0:63]  iLenC;
   logic [0:127] iTag_ref;
   logic         oReady;
   logic         oBusy;
   logic [0:127] oTag;
   logic         oTag_valid;
   logic         oTag_match;

   ghash_tag_block dut (
      .iClk(iClk), .iRstn(iRstn), .iInit(iInit),
      .iH(iH), .iH_valid(iH_valid), .iEk0(iEk0), .iEk0_valid(iEk0_valid),
      .iAad(iAad), .iAad_valid(iAad_valid), .iCt(iCt), .iCt_valid(iCt_valid),
      .iFinal(iFinal), .iLenA(iLenA), .iLenC(iLenC), .iTag_ref(iTag_ref),
      .oReady(oReady), .oBusy(oBusy), .oTag(oTag), .oTag_valid(oTag_valid),
      .oTag_match(oTag_match)
   );

   always #5 iClk = ~iClk;

   localparam logic [0:127] H_K     = 128'h286D73994EA0BA3CFD1F52BF06A8ACF2;
   localparam logic [0:127] EK0_K   = 128'h714D54FDCFCEE37D5729CDDAB383A016;
   localparam logic [0:127] A1      = 128'hD609B1F056637A0D46DF998D88E52E00;
   localparam logic [0:127] A2      = 128'hB2C2846512153524C0895E8100000000;
   localparam logic [0:127] C1      = 128'hE2006EB42F5277022D9B19925BC419D7;
   localparam logic [0:127] C2      = 128'hA592666C925FE2EF718EB4E308EFEAA7;
   localparam logic [0:127] C3      = 128'hC5273B394118860A5BE2A97F56AB7836;
   localparam logic [0:127] Y1_K    = 128'hD62D2B0792C282A27B82C3731ABCB7A1;
   localparam logic [0:127] Y5_K    = 128'h6D109A3C7F34085754FDDFF0EB5D4595;
   localparam logic [0:127] GHASH_K = 128'h2DE8C33074F038F04D389C30B9741420;
   localparam logic [0:127] TAG_K   = 128'h5CA597CDBB3EDB8D1A1151EA0AF7B436;

   int n_chk  = 0;
   int n_pass = 0;
   bit check_en = 1'b0;

   task automatic chk(input string nm, input logic [0:127] a, input logic [0:127] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, a, e);
   endtask

   task automatic chk1(input string nm, input logic a, input logic e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %b want %b", nm, a, e);
   endtask

   task automatic chk_int(input string nm, input int a, input int e);
      n_chk++;
      if (a == e) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, a, e);
   endtask

   // Coefficient of x^i is bit i; carry-less product then reduce by x^128+x^7+x^2+x+1.
   function automatic logic [0:127] gf_mul(input logic [0:127] a, input logic [0:127] b);
      logic [0:254] p;
      p = '0;
      for (int i = 0; i < 128; i++)
         if (a[i]) p[i +: 128] = p[i +: 128] ^ b;
      for (int k = 254; k >= 128; k--)
         if (p[k]) begin
            p[k]       = 1'b0;
            p[k - 121] = ~p[k - 121];
            p[k - 126] = ~p[k - 126];
            p[k - 127] = ~p[k - 127];
            p[k - 128] = ~p[k - 128];
         end
      return p[0:127];
   endfunction

   logic [0:127] m_h = '0, m_hn = '0, m_ek0 = '0, m_y = '0, m_prod = '0, m_tref = '0, m_tag = '0;
   bit m_haskey = 0, m_done = 0, m_final = 0, m_ready = 0, m_busy = 0, m_valid = 0, m_match = 0;
   int m_rem = 0;

   // Model: result computed at accept, published after 128 further edges.
   always @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         m_h = '0; m_ek0 = '0; m_y = '0; m_prod = '0; m_tref = '0; m_tag = '0;
         m_haskey = 0; m_done = 0; m_final = 0; m_ready = 0; m_busy = 0;
         m_valid = 0; m_match = 0; m_rem = 0;
      end else if (!m_haskey) begin
         if (iEk0_valid) m_ek0 = iEk0;
         if (iH_valid) begin
            m_h = iH; m_haskey = 1; m_ready = 1;
         end
      end else begin
         m_hn = (iH_valid && (m_rem == 0 || iInit)) ? iH : m_h;
         if (iInit) begin
            m_y = '0; m_tag = '0; m_valid = 0; m_match = 0;
            m_rem = 0; m_done = 0; m_ready = 1; m_busy = 0;
         end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_y = m_prod; m_busy = 0;
               if (m_final) begin
                  m_tag = m_prod ^ m_ek0; m_valid = 1;
                  m_match = (m_tag == m_tref); m_done = 1;
               end else m_ready = 1;
            end
         end else if (!m_done) begin
            if (iAad_valid || iCt_valid) begin
               m_prod = gf_mul(m_y ^ (iAad_valid ? iAad : iCt), m_h);
               m_final = 0; m_rem = 128; m_ready = 0; m_busy = 1;
            end else if (iFinal) begin
               m_prod = gf_mul(m_y ^ {iLenA, iLenC}, m_h);
               m_tref = iTag_ref;
               m_final = 1; m_rem = 128; m_ready = 0; m_busy = 1;
            end
         end
         m_h = m_hn;
         if (iEk0_valid) m_ek0 = iEk0;
      end
   end

   always @(negedge iClk) begin
      if (check_en) begin
         chk1("cyc_oReady", oReady, m_ready);
         chk1("cyc_oBusy", oBusy, m_busy);
         chk1("cyc_oTag_valid", oTag_valid, m_valid);
         chk1("cyc_oTag_match", oTag_match, m_match);
         chk("cyc_oTag", oTag, m_tag);
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!oReady && t < 400) begin
         @(negedge iClk);
         t++;
      end
      if (!oReady) begin
         n_chk++;
         $display("FAIL ready_timeout: oReady=%b want 1", oReady);
      end
   endtask

   task automatic pulse_init();
      iInit = 1'b1;
      @(negedge iClk);
      iInit = 1'b0;
   endtask

   task automatic send_blk(input bit is_ct, input logic [0:127] d);
      int lo = 0;
      wait_ready();
      if (is_ct) begin iCt = d; iCt_valid = 1'b1; end
      else begin iAad = d; iAad_valid = 1'b1; end
      @(negedge iClk);
      iAad_valid = 1'b0;
      iCt_valid  = 1'b0;
      while (!oReady && lo < 300) begin
         lo++;
         @(negedge iClk);
      end
      chk_int("ready_low_cycles", lo, 128);
   endtask

   task automatic send_final(input logic [0:127] tref);
      int lat = 0;
      wait_ready();
      iLenA = 64'hE0; iLenC = 64'h180; iTag_ref = tref; iFinal = 1'b1;
      @(negedge iClk);
      iFinal = 1'b0;
      while (!oTag_valid && lat < 300) begin
         lat++;
         @(negedge iClk);
      end
      chk_int("tag_latency_edges", lat + 1, 129);
   endtask

   task automatic run_vec(input logic [0:127] tref);
      send_blk(1'b0, A1);
      chk("y1_dut", dut.y_q, Y1_K);
      chk("y1_model", m_y, Y1_K);
      send_blk(1'b0, A2);
      send_blk(1'b1, C1);
      send_blk(1'b1, C2);
      send_blk(1'b1, C3);
      chk("y5_dut", dut.y_q, Y5_K);
      send_final(tref);
      chk("ghash_dut", dut.y_q, GHASH_K);
      chk("ghash_model", m_y, GHASH_K);
      chk("tag_literal", oTag, TAG_K);
      chk1("tag_valid", oTag_valid, 1'b1);
   endtask

   initial begin
      int n1, n2;
      bit pb;
      iRstn = 1'b0; iInit = 1'b0; iH = '0; iH_valid = 1'b0; iEk0 = '0; iEk0_valid = 1'b0;
      iAad = '0; iAad_valid = 1'b0; iCt = '0; iCt_valid = 1'b0; iFinal = 1'b0;
      iLenA = '0; iLenC = '0; iTag_ref = '0;
      repeat (2) @(negedge iClk);
      check_en = 1'b1;
      chk1("rst_ready", oReady, 1'b0);
      chk1("rst_busy", oBusy, 1'b0);
      chk1("rst_valid", oTag_valid, 1'b0);
      chk("rst_tag", oTag, '0);
      iRstn = 1'b1;

      // No key yet: blocks and final ignored.
      @(negedge iClk);
      iAad = A1; iAad_valid = 1'b1; iFinal = 1'b1;
      repeat (3) @(negedge iClk);
      chk1("nokey_ready", oReady, 1'b0);
      chk1("nokey_busy", oBusy, 1'b0);
      iAad_valid = 1'b0; iFinal = 1'b0;

      iH = H_K; iH_valid = 1'b1; iEk0 = EK0_K; iEk0_valid = 1'b1;
      @(negedge iClk);
      iH_valid = 1'b0; iEk0_valid = 1'b0;
      chk1("key_ready", oReady, 1'b1);

      // Encrypt path.
      run_vec('0);
      chk1("enc_match", oTag_match, 1'b0);

      // DONE ignores blocks.
      iCt = C1; iCt_valid = 1'b1;
      repeat (3) @(negedge iClk);
      chk1("done_busy", oBusy, 1'b0);
      chk("done_tag_held", oTag, TAG_K);
      iCt_valid = 1'b0;

      // Decrypt path, good and corrupted reference.
      pulse_init();
      chk1("init_valid", oTag_valid, 1'b0);
      run_vec(TAG_K);
      chk1("dec_match", oTag_match, 1'b1);
      pulse_init();
      run_vec(TAG_K ^ 128'h1);
      chk1("dec_mismatch", oTag_match, 1'b0);

      // AAD and CT offered together: AAD first, CT 129 cycles later.
      pulse_init();
      wait_ready();
      iAad = A1; iCt = C1; iAad_valid = 1'b1; iCt_valid = 1'b1;
      n1 = -1; n2 = -1; pb = oBusy;
      for (int i = 0; i < 400 && n2 < 0; i++) begin
         @(negedge iClk);
         if (oBusy && !pb) begin
            if (n1 < 0) begin n1 = i; iAad_valid = 1'b0; end
            else begin n2 = i; iCt_valid = 1'b0; end
         end
         pb = oBusy;
      end
      iAad_valid = 1'b0; iCt_valid = 1'b0;
      chk_int("accept_gap", n2 - n1, 129);
      wait_ready();
      chk("prio_y", dut.y_q, gf_mul(gf_mul(A1, H_K) ^ C1, H_K));

      // Abort at step 60, then the full vector again.
      pulse_init();
      wait_ready();
      iAad = A1; iAad_valid = 1'b1;
      @(negedge iClk);
      iAad_valid = 1'b0;
      repeat (60) @(negedge iClk);
      chk1("pre_abort_busy", oBusy, 1'b1);
      pulse_init();
      chk1("abort_ready", oReady, 1'b1);
      chk1("abort_busy", oBusy, 1'b0);
      chk("abort_y", dut.y_q, '0);
      run_vec(TAG_K);
      chk1("rerun_match", oTag_match, 1'b1);

      // Reset during the length-block multiply.
      pulse_init();
      send_blk(1'b0, A1);
      iLenA = 64'hE0; iLenC = 64'h180; iFinal = 1'b1;
      @(negedge iClk);
      iFinal = 1'b0;
      repeat (50) @(negedge iClk);
      chk1("fin_busy", oBusy, 1'b1);
      #2 iRstn = 1'b0;
      @(negedge iClk);
      chk1("midfin_rst_busy", oBusy, 1'b0);
      chk1("midfin_rst_ready", oReady, 1'b0);
      chk("midfin_rst_y", dut.y_q, '0);
      #2 iRstn = 1'b1;
      @(negedge iClk);
      iFinal = 1'b1;
      repeat (3) @(negedge iClk);
      chk1("nokey_final_busy", oBusy, 1'b0);
      chk1("nokey_final_valid", oTag_valid, 1'b0);
      iFinal = 1'b0;
      iH = H_K; iH_valid = 1'b1;
      @(negedge iClk);
      iH_valid = 1'b0;
      chk1("reload_ready", oReady, 1'b1);

      repeat (2) @(negedge iClk);
      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
